lcd_bus_receiver: RTL and testbench
===================================

// Module: lcd_bus_receiver
// PURPOSE
// - Receiving end of the HD44780-style character-LCD write bus (LCD_E/RS/RW/DATA) driven by the text LCD driver.
// - Decodes instructions and data writes into a 2x16 character shadow buffer, cursor address and display flags.
// - Exposes the shadow buffer through a read port, so the clock/stopwatch/alarm screens can be checked cycle-accurately in simulation.
// - Also synthesizable as an on-chip bus monitor.
// PARAMETERS
// - CLEAR_CYCLES  100  busy duration after clear-display / return-home (clk cycles, >=1)
// - CMD_CYCLES    4    busy duration after any other accepted strobe (clk cycles, >=1)
// PORTS
// - clk           in   1  system clock; every input is synchronous to it
// - resetn        in   1  asynchronous active-low reset
// - LCD_E         in   1  enable strobe; a transfer completes on its falling edge
// - LCD_RS        in   1  0 = instruction, 1 = data
// - LCD_RW        in   1  0 = write, 1 = read (read accepted, no state change)
// - LCD_DATA      in   8  instruction/character byte
// - rd_addr       in   5  buffer read index: [4] = line, [3:0] = column
// - rd_char       out  8  registered buffer byte at rd_addr, 1-cycle latency
// - cursor_addr   out  7  current DDRAM address counter (AC)
// - display_on    out  1  D bit of the last display-control instruction
// - two_line      out  1  N bit of the last function-set instruction
// - busy          out  1  high while an instruction is executing
// - write_pulse   out  1  1-cycle pulse when a data byte lands in the buffer
// - protocol_err  out  1  sticky; cleared only by reset
// BEHAVIOUR
// - Reset values: all 32 buffer bytes 8'h20; rd_char 8'h20; cursor_addr 0; display_on 0; two_line 0; busy 0; write_pulse 0; protocol_err 0; increment mode 1.
// - Strobe detection: register LCD_E as e_q.
//   - strobe = e_q & ~LCD_E.
//   - RS/RW/DATA are captured every cycle while LCD_E=1; the captured copy is decoded on the strobe cycle.
//   - State updates land the cycle after the strobe.
// - Busy: strobe with busy=1 sets protocol_err; the transfer is dropped.
//   - Otherwise an accepted RW=0 strobe loads the busy counter with CMD_CYCLES, or CLEAR_CYCLES for clear/home.
//   - busy = (counter != 0).
//   - RW=1 strobes are ignored entirely; they do not set busy.
// - Instructions (RS=0), decoded by the highest set bit:
//   - 8'h01 clear: all bytes 8'h20, AC=0, increment=1.
//   - 8'h02/03 home: AC=0.
//   - 8'h04-07 entry mode: increment=DATA[1]; the shift bit is ignored.
//   - 8'h08-0F display control: display_on=DATA[2].
//   - 8'h10-1F shift: if S/C=0, move AC one step per R/L (same wrap as data writes); display shift is ignored.
//   - 8'h20-3F function set: two_line=DATA[3].
//   - 8'h40-7F CGRAM address: unsupported; sets protocol_err, no other change.
//   - 8'h80-FF DDRAM address: if DATA[6:0] is in 00-27 or 40-67, AC=DATA[6:0]; else protocol_err=1 and AC is unchanged.
// - Data write (RS=0 vs RS=1): RS=1 writes DATA into the buffer.
//   - AC 00-0F maps to line 0, column AC[3:0].
//   - AC 40-4F maps to line 1, column AC[3:0].
//   - Any other valid AC is off-screen: no buffer write and no write_pulse, but AC still advances.
// - AC stepping: increment 27->40, 67->00; decrement 40->27, 00->67.
// - Simultaneous events: strobe on the same cycle busy reaches 0 counts as busy.
// - Reset mid-operation (e.g. during clear-busy) returns everything to reset values immediately.
// STRUCTURE
// - Shared package lcd_pkg:
//   - instruction opcode masks and a decode enum {CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM}
//   - LCD_SPACE=8'h20; LINE0_BASE=7'h00, LINE1_BASE=7'h40, LINE_LAST_OFS=7'h27
// - Sub-module lcd_strobe_capture: E edge detect plus RS/RW/DATA latch; outputs strobe, rs, rw, data.
// - Top holds the decoder, busy counter, AC logic and a 32x8 register buffer.
// TESTING
// - Reset check: after reset, every rd_addr 0..31 -> rd_char 8'h20; busy=0, cursor_addr=0.
// - Init and write: 38,0C,06,01 each honoring busy, then data "12" -> rd[0]=31, rd[1]=32, cursor_addr=02, display_on=1, two_line=1, two write_pulses.
// - Line-1 write: instruction C0 then data 'A' -> rd[16]=41, cursor_addr=41.
// - Wrap: A7 then data 'X' -> no buffer change, no write_pulse, cursor_addr=40.
//   - Then entry mode 04, AC=00, data 'Y' -> rd[0]=59, cursor_addr=67.
// - Busy violation: 01, then data strobe 10 cycles later (CLEAR_CYCLES=100) -> protocol_err=1, buffer all 20.
//   - Also 48 (CGRAM) -> protocol_err=1.
// - Reset mid-clear: resetn low 2 cycles while busy -> busy=0, protocol_err=0, buffer all 20; the next strobe is accepted.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, instruction decode and address-counter helpers
// Contents:
//   LCD_SPACE, LINE0_BASE, LINE1_BASE, LINE_LAST_OFS  DDRAM layout constants
//   MASK_*                                            instruction opcode masks
//   lcd_op_e                                          decoded instruction class
//   decode_op(data)                                   class chosen by the highest set bit
//   ac_valid(ac), ac_on_screen(ac), ac_step(ac, inc)  address-counter helpers
package lcd_pkg;

  localparam logic [7:0] LCD_SPACE     = 8'h20;
  localparam logic [6:0] LINE0_BASE    = 7'h00;
  localparam logic [6:0] LINE1_BASE    = 7'h40;
  localparam logic [6:0] LINE_LAST_OFS = 7'h27;

  localparam logic [7:0] MASK_CLR   = 8'h01;
  localparam logic [7:0] MASK_HOME  = 8'h02;
  localparam logic [7:0] MASK_ENTRY = 8'h04;
  localparam logic [7:0] MASK_DISP  = 8'h08;
  localparam logic [7:0] MASK_SHIFT = 8'h10;
  localparam logic [7:0] MASK_FUNC  = 8'h20;
  localparam logic [7:0] MASK_CGRAM = 8'h40;
  localparam logic [7:0] MASK_DDRAM = 8'h80;

  // NOP covers 8'h00, which has no set bit and changes nothing.
  typedef enum logic [3:0] {
    NOP, CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM
  } lcd_op_e;

  function automatic lcd_op_e decode_op(input logic [7:0] d);
    if ((d & MASK_DDRAM) != 8'h00) return DDRAM;
    if ((d & MASK_CGRAM) != 8'h00) return CGRAM;
    if ((d & MASK_FUNC)  != 8'h00) return FUNC;
    if ((d & MASK_SHIFT) != 8'h00) return SHIFT;
    if ((d & MASK_DISP)  != 8'h00) return DISP;
    if ((d & MASK_ENTRY) != 8'h00) return ENTRY;
    if ((d & MASK_HOME)  != 8'h00) return HOME;
    if ((d & MASK_CLR)   != 8'h00) return CLR;
    return NOP;
  endfunction

  function automatic logic ac_valid(input logic [6:0] a);
    return (a <= LINE0_BASE + LINE_LAST_OFS) ||
           ((a >= LINE1_BASE) && (a <= LINE1_BASE + LINE_LAST_OFS));
  endfunction

  // Only the first 16 addresses of each line are backed by the buffer.
  function automatic logic ac_on_screen(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  // The two 40-byte lines form one ring: 27 <-> 40 and 67 <-> 00.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE0_BASE + LINE_LAST_OFS) return LINE1_BASE;
      if (a == LINE1_BASE + LINE_LAST_OFS) return LINE0_BASE;
      return a + 7'd1;
    end
    if (a == LINE1_BASE) return LINE0_BASE + LINE_LAST_OFS;
    if (a == LINE0_BASE) return LINE1_BASE + LINE_LAST_OFS;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_if.sv
// rtl/lcd_bus_if.sv - HD44780-style LCD write bus
// Signals:
//   LCD_E     enable strobe, transfer completes on its falling edge
//   LCD_RS    0 = instruction, 1 = data
//   LCD_RW    0 = write, 1 = read
//   LCD_DATA  instruction/character byte
// Modports: master drives the bus, slave receives it.
interface lcd_bus_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (output LCD_E, LCD_RS, LCD_RW, LCD_DATA);
  modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_DATA);
endinterface

// File: rtl/lcd_strobe_capture.sv
// rtl/lcd_strobe_capture.sv - E falling-edge detect with RS/RW/DATA capture
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   lcd_e, lcd_rs, lcd_rw        raw bus control inputs
//   lcd_data                     raw bus byte
//   strobe                       high for the cycle in which E has just fallen
//   rs, rw, data                 bus values captured while E was high
module lcd_strobe_capture (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);

  logic e_q;

  // The captured copy is frozen once E drops, so the bus may change
  // on the falling edge itself without corrupting the transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q  <= 1'b0;
      rs   <= 1'b0;
      rw   <= 1'b0;
      data <= 8'h00;
    end else begin
      e_q <= lcd_e;
      if (lcd_e) begin
        rs   <= lcd_rs;
        rw   <= lcd_rw;
        data <= lcd_data;
      end
    end
  end

  assign strobe = e_q & ~lcd_e;

endmodule

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - LCD write-bus receiver with 2x16 shadow buffer
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   bus              LCD write bus (slave side)
//   rd_addr          buffer read index, [4] = line, [3:0] = column
//   rd_char          registered buffer byte at rd_addr, 1-cycle latency
//   cursor_addr      DDRAM address counter
//   display_on       D bit of the last display-control instruction
//   two_line         N bit of the last function-set instruction
//   busy             high while an instruction is executing
//   write_pulse      one cycle per data byte landing in the buffer
//   protocol_err     sticky error flag, cleared only by reset
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int CLEAR_CYCLES = 100,
  parameter int CMD_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  lcd_bus_if.slave   bus,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       two_line,
  output logic       busy,
  output logic       write_pulse,
  output logic       protocol_err
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             strobe;
  logic             cap_rs;
  logic             cap_rw;
  logic [7:0]       cap_data;
  logic [CNT_W-1:0] busy_cnt;
  logic             inc_mode;
  logic [7:0]       mem [32];
  lcd_op_e          op;

  lcd_strobe_capture u_capture (
    .clk      (clk),
    .resetn   (resetn),
    .lcd_e    (bus.LCD_E),
    .lcd_rs   (bus.LCD_RS),
    .lcd_rw   (bus.LCD_RW),
    .lcd_data (bus.LCD_DATA),
    .strobe   (strobe),
    .rs       (cap_rs),
    .rw       (cap_rw),
    .data     (cap_data)
  );

  assign op   = decode_op(cap_data);
  assign busy = (busy_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mem[i] <= LCD_SPACE;
      rd_char      <= LCD_SPACE;
      cursor_addr  <= LINE0_BASE;
      inc_mode     <= 1'b1;
      display_on   <= 1'b0;
      two_line     <= 1'b0;
      protocol_err <= 1'b0;
      write_pulse  <= 1'b0;
      busy_cnt     <= '0;
    end else begin
      write_pulse <= 1'b0;
      rd_char     <= mem[rd_addr];
      if (busy) busy_cnt <= busy_cnt - CNT_W'(1);

      // Reads are ignored outright; a write while busy (including the
      // cycle the counter is about to reach zero) is dropped and flagged.
      if (strobe && !cap_rw) begin
        if (busy) begin
          protocol_err <= 1'b1;
        end else begin
          busy_cnt <= (!cap_rs && (op == CLR || op == HOME)) ?
                      CNT_W'(CLEAR_CYCLES) : CNT_W'(CMD_CYCLES);
          if (cap_rs) begin
            // Off-screen addresses still advance the counter.
            if (ac_on_screen(cursor_addr)) begin
              mem[{cursor_addr[6], cursor_addr[3:0]}] <= cap_data;
              write_pulse <= 1'b1;
            end
            cursor_addr <= ac_step(cursor_addr, inc_mode);
          end else begin
            case (op)
              CLR: begin
                for (int i = 0; i < 32; i++) mem[i] <= LCD_SPACE;
                cursor_addr <= LINE0_BASE;
                inc_mode    <= 1'b1;
              end
              HOME:  cursor_addr <= LINE0_BASE;
              ENTRY: inc_mode    <= cap_data[1];
              DISP:  display_on  <= cap_data[2];
              SHIFT: if (!cap_data[3]) cursor_addr <= ac_step(cursor_addr, cap_data[2]);
              FUNC:  two_line    <= cap_data[3];
              CGRAM: protocol_err <= 1'b1;
              DDRAM: begin
                if (ac_valid(cap_data[6:0])) cursor_addr  <= cap_data[6:0];
                else                         protocol_err <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - self-checking bench for lcd_bus_receiver
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       display_on;
  logic       two_line;
  logic       busy;
  logic       write_pulse;
  logic       protocol_err;

  lcd_bus_if bus ();

  lcd_bus_receiver #(.CLEAR_CYCLES(100), .CMD_CYCLES(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus.slave),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .cursor_addr  (cursor_addr),
    .display_on   (display_on),
    .two_line     (two_line),
    .busy         (busy),
    .write_pulse  (write_pulse),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] ch;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] model_mem [32];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         pulse_cnt = 0;
  int         pulse_base = 0;

  always @(negedge clk) if (write_pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h20;
  endtask

  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_DATA = d; bus.LCD_E = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Scramble the bus as E falls: only the captured copy may be used.
    bus.LCD_E = 1'b0; bus.LCD_RS = ~rs; bus.LCD_DATA = ~d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d);
    int n;
    wait_idle(n);
    bus_xfer(rs, 1'b0, d);
  endtask

  // Data write; idx >= 0 means the byte is expected to land in the buffer.
  task automatic put_char(input logic [7:0] ch, input int idx);
    if (idx >= 0) begin
      wr_t w;
      w.idx = idx; w.ch = ch;
      exp_q.push_back(w);
      model_mem[idx] = ch;
    end
    lcd_write(1'b1, ch);
  endtask

  task automatic read_buf(input int idx, output logic [7:0] v);
    @(posedge clk); #1 rd_addr = 5'(idx);
    @(posedge clk);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic drain();
    int n;
    logic [7:0] v;
    wait_idle(n);
    check("write_pulses", 32'(pulse_cnt - pulse_base), 32'(exp_q.size()));
    pulse_base = pulse_cnt;
    while (exp_q.size() > 0) begin
      wr_t w;
      w = exp_q.pop_front();
      read_buf(w.idx, v);
      check($sformatf("rd[%0d]", w.idx), 32'(v), 32'(w.ch));
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_buf(i, v);
      check($sformatf("%s[%0d]", tag, i), 32'(v), 32'(model_mem[i]));
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_clear();
    exp_q.delete();
    pulse_base = pulse_cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    rd_addr = 5'd0;
    bus.LCD_E = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cursor", 32'(cursor_addr), 32'h00);
    check("rst_display_on", 32'(display_on), 32'd0);
    check("rst_two_line", 32'(two_line), 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    check("rst_rd_char", 32'(rd_char), 32'h20);
    check_all("rst_buf");

    // Init sequence with busy timing.
    bus_xfer(1'b0, 1'b0, 8'h38);
    wait_idle(n);
    check("cmd_busy_cycles", 32'(n), 32'd4);
    lcd_write(1'b0, 8'h0C);
    lcd_write(1'b0, 8'h06);
    wait_idle(n);
    bus_xfer(1'b0, 1'b0, 8'h01);
    model_clear();
    wait_idle(n);
    check("clear_busy_cycles", 32'(n), 32'd100);
    put_char(8'h31, 0);
    put_char(8'h32, 1);
    drain();
    check("init_cursor", 32'(cursor_addr), 32'h02);
    check("init_display_on", 32'(display_on), 32'd1);
    check("init_two_line", 32'(two_line), 32'd1);

    // Line 1.
    lcd_write(1'b0, 8'hC0);
    put_char(8'h41, 16);
    drain();
    check("line1_cursor", 32'(cursor_addr), 32'h41);

    // Off-screen write and wrap 27 -> 40.
    lcd_write(1'b0, 8'hA7);
    put_char(8'h58, -1);
    drain();
    check("wrap_cursor", 32'(cursor_addr), 32'h40);

    // Decrement mode, wrap 00 -> 67.
    lcd_write(1'b0, 8'h04);
    lcd_write(1'b0, 8'h80);
    put_char(8'h59, 0);
    drain();
    check("dec_cursor", 32'(cursor_addr), 32'h67);
    check_all("after_wrap");

    // Cursor shifts: right from 67 wraps to 00, left from 00 wraps to 67.
    lcd_write(1'b0, 8'h14);
    drain();
    check("shift_right_cursor", 32'(cursor_addr), 32'h00);
    lcd_write(1'b0, 8'h10);
    drain();
    check("shift_left_cursor", 32'(cursor_addr), 32'h67);
    check("no_err_yet", 32'(protocol_err), 32'd0);

    // Busy violation: data strobe during clear-busy is dropped.
    wait_idle(n);
    bus_xfer(1'b0, 1'b0, 8'h01);
    model_clear();
    repeat (8) @(posedge clk);
    bus_xfer(1'b1, 1'b0, 8'h56);
    check("busy_violation_err", 32'(protocol_err), 32'd1);
    drain();
    check_all("violation_buf");

    // Reset in the middle of a clear.
    lcd_write(1'b0, 8'h01);
    repeat (5) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    @(posedge clk); #1 resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err", 32'(protocol_err), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    model_clear();
    exp_q.delete();
    pulse_base = pulse_cnt;
    check_all("rst_mid_buf");
    put_char(8'h5A, 0);
    drain();
    check("after_rst_cursor", 32'(cursor_addr), 32'h01);

    // Read strobe changes nothing and does not set busy.
    bus_xfer(1'b0, 1'b1, 8'h01);
    check("read_busy", 32'(busy), 32'd0);
    check("read_cursor", 32'(cursor_addr), 32'h01);

    // CGRAM address is unsupported.
    lcd_write(1'b0, 8'h48);
    check("cgram_err", 32'(protocol_err), 32'd1);
    check("cgram_cursor", 32'(cursor_addr), 32'h01);

    // Invalid DDRAM address.
    apply_reset();
    @(negedge clk);
    check("rst2_err", 32'(protocol_err), 32'd0);
    lcd_write(1'b0, 8'h85);
    lcd_write(1'b0, 8'hA8);
    check("bad_ddram_err", 32'(protocol_err), 32'd1);
    check("bad_ddram_cursor", 32'(cursor_addr), 32'h05);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
